// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : IF stage -- PC sequencing, imem handshake, 1-entry skid
// Revision: 1.0
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] PC_START = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_fetch = 2'd1;
  localparam logic [1:0] c_hold  = 2'd2;
  localparam logic [1:0] c_drop  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_skid_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        w_advance;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_inc;

  assign w_advance     = !r_if_valid || !stall;
  assign w_redirect    = redirect_valid && (r_state != c_idle);
  assign w_redirect_pc = redirect_pc & ~32'd3;
  assign w_pc_inc      = r_pc + 32'd4;

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  w_next_state = c_fetch;
      c_fetch: begin
        if (w_redirect)                  w_next_state = imem_ack ? c_fetch : c_drop;
        else if (imem_ack && !w_advance) w_next_state = c_hold;
      end
      c_hold:  if (w_redirect || !stall) w_next_state = c_fetch;
      c_drop:  if (!w_redirect && imem_ack) w_next_state = c_fetch;
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    case (r_state)
      c_fetch: imem_req = 1'b1;
      c_drop: begin
        imem_req  = 1'b1;
        imem_addr = r_req_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= PC_START;
      r_req_addr   <= PC_START;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'd0;
      r_if_instr   <= 32'd0;
    end else begin
      // Snapshot of the address on the bus, kept for the DROP drain.
      if (r_state == c_fetch) r_req_addr <= r_pc;
      if (w_redirect) begin
        r_if_valid   <= 1'b0;
        r_skid_valid <= 1'b0;
        r_pc         <= w_redirect_pc;
      end else begin
        case (r_state)
          c_fetch: begin
            if (imem_ack) begin
              r_pc <= w_pc_inc;
              if (w_advance) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_instr <= imem_rdata;
              end else begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_pc;
                r_skid_instr <= imem_rdata;
              end
            end else if (w_advance) begin
              // Decode consumed the word and nothing replaces it yet.
              r_if_valid <= 1'b0;
            end
          end
          c_hold: begin
            if (!stall) begin
              r_if_valid   <= r_skid_valid;
              r_if_pc      <= r_skid_pc;
              r_if_instr   <= r_skid_instr;
              r_skid_valid <= 1'b0;
            end
          end
          default: if (w_advance) r_if_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : directed stimulus, queue scoreboard on IF/ID transfers
// Revision: 1.0
// ============================================================================
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int          checks;
  int          failures;
  int          mem_delay;
  int          mem_cnt;
  logic [31:0] exp_q[$];

  localparam logic [31:0] c_xor = 32'hA5A5_A5A5;

  fetch_sequencer #(.PC_START(32'h0000_3000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory: acks a request once it has waited mem_delay cycles.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    mem_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_ack) mem_cnt = 0;
      imem_ack   = imem_req && (mem_cnt >= mem_delay);
      imem_rdata = imem_addr ^ c_xor;
      if (imem_req && !imem_ack) mem_cnt++;
      if (!imem_req) mem_cnt = 0;
    end
  end

  // Monitor: a word presented with stall low is taken at the next edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset && if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr: got pc %h, none expected", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", if_pc, e);
          chk("sb_instr", if_instr, e ^ c_xor);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; mem_delay = 0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);

    // Streaming with a 3-cycle stall on 3004; 3008 waits in the skid.
    reset = 1'b1;
    exp_q.push_back(32'h0000_3000); exp_q.push_back(32'h0000_3004);
    exp_q.push_back(32'h0000_3008); exp_q.push_back(32'h0000_300C);
    exp_q.push_back(32'h0000_3010);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);
    step();
    chk("pc_3000", if_pc, 32'h0000_3000);
    step();
    chk("pc_3004", if_pc, 32'h0000_3004);
    stall = 1'b1;
    step();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc", if_pc, 32'h0000_3004);
    step(); step();
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    stall = 1'b0;
    step();
    chk("skid_pc", if_pc, 32'h0000_3008);
    chk("after_hold_addr", imem_addr, 32'h0000_300C);
    step();
    mem_delay = 3;
    step();

    // Redirect in the first wait cycle of a slow request.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4002;
    exp_q.push_back(32'h0000_4000);
    step();
    redirect_valid = 1'b0;
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_addr0", imem_addr, 32'h0000_3014);
    chk("drop_valid0", {31'd0, if_valid}, 32'd0);
    step();
    chk("drop_addr1", imem_addr, 32'h0000_3014);
    chk("drop_valid1", {31'd0, if_valid}, 32'd0);
    step();
    mem_delay = 0;
    chk("drop_addr2", imem_addr, 32'h0000_3014);
    step();
    chk("refetch_addr", imem_addr, 32'h0000_4000);
    chk("refetch_valid", {31'd0, if_valid}, 32'd0);
    step();
    chk("pc_4000", if_pc, 32'h0000_4000);

    // Redirect beats stall and a same-cycle ack; 4000 is flushed unconsumed.
    void'(exp_q.pop_back());
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
    step();
    chk("rsa_valid", {31'd0, if_valid}, 32'd0);
    chk("rsa_addr", imem_addr, 32'h0000_5000);
    stall = 1'b0; redirect_valid = 1'b0;
    exp_q.push_back(32'h0000_5000);
    step();

    // Wrap at the top of the address space; low bits of the target ignored.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
    mem_delay = 3;
    step();
    chk("wrap_pc1", if_pc, 32'h0000_0000);

    // Asynchronous reset in the middle of DROP.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_6000;
    step();
    redirect_valid = 1'b0;
    chk("drop2_addr", imem_addr, 32'h0000_0004);
    #1 reset = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0000_3000);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_instr", if_instr, 32'd0);
    mem_delay = 0;
    step(); step();
    reset = 1'b1;
    exp_q.push_back(32'h0000_3000); exp_q.push_back(32'h0000_3004);
    step();
    chk("restart_addr", imem_addr, 32'h0000_3000);
    step();
    chk("restart_pc", if_pc, 32'h0000_3000);
    step();
    @(negedge clk);
    #1 reset = 1'b0;
    step();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: Parameter PC_START, default 32'h0000_3000, PC loaded on reset.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004: stall  input  1  decode stage cannot accept; hold IF/ID output.
REQ-005: redirect_valid  input  1  branch/jump resolved; flush and refetch.
REQ-006: redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 00.
REQ-007: imem_req  output  1  instruction memory read request.
REQ-008: imem_addr  output  32  word address of request; stable while imem_req=1 and no ack.
REQ-009: imem_ack  input  1  read complete this cycle; meaningful only when imem_req=1.
REQ-010: imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-011: if_valid  output  1  if_pc/if_instr hold a live instruction.
REQ-012: if_pc  output  32  PC of presented instruction.
REQ-013: if_instr  output  32  presented instruction word.

Function
REQ-014: States IDLE, FETCH, HOLD, DROP; imem_req=1 exactly in FETCH and DROP, registered-state decode only.
REQ-015: Internal regs: pc_r (next fetch PC), req_addr (address of outstanding request), one-entry skid buffer (skid_valid, skid_pc, skid_instr).
REQ-016: IDLE -> FETCH unconditionally on first clk edge after reset release.
REQ-017: In FETCH, imem_addr = pc_r; req_addr tracks pc_r; in DROP, imem_addr = req_addr.
REQ-018: advance = !if_valid || !stall.
REQ-019: FETCH, ack, advance, no redirect: if_valid<=1, if_pc<=pc_r, if_instr<=imem_rdata, pc_r<=pc_r+4, stay FETCH (back-to-back, one instr/cycle with single-cycle ack).
REQ-020: FETCH, ack, !advance, no redirect: skid<=(pc_r, imem_rdata), skid_valid<=1, pc_r<=pc_r+4, go HOLD.
REQ-021: FETCH, no ack: hold pc_r, imem_addr unchanged, outputs unchanged except stall-independent flush rules.
REQ-022: HOLD, !stall, no redirect: if_pc/if_instr<=skid, if_valid<=1, skid_valid<=0, go FETCH.
REQ-023: Redirect (any state except IDLE) has priority over stall and ack: if_valid<=0, skid_valid<=0, pc_r<={redirect_pc[31:2],2'b00}.
REQ-024: Redirect next state: FETCH with ack same cycle -> FETCH (returned word discarded); FETCH without ack -> DROP; HOLD -> FETCH; DROP -> DROP.
REQ-025: DROP: keep imem_req=1, imem_addr=req_addr until ack; on ack discard imem_rdata, go FETCH with pc_r; no instruction from DROP ever reaches if_*.
REQ-026: When !advance and not in a transition above, if_valid/if_pc/if_instr hold.
REQ-027: PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-028: imem_ack while imem_req=0 is ignored.

Reset
REQ-029: While reset=0: state=IDLE, pc_r=PC_START, req_addr=PC_START, skid_valid=0, imem_req=0, if_valid=0, if_pc=0, if_instr=0, immediately without a clock edge.
REQ-030: Reset asserted mid-request (FETCH/DROP) abandons the request; the memory returns to idle on imem_req=0.

Verification
REQ-031: Release reset, ack every cycle, rdata=PC^32'hA5A5_A5A5 -> imem_req high from 2nd cycle; if_pc sequence 3000,3004,3008 on consecutive cycles, if_valid=1.
REQ-032: Ack each cycle, stall=1 while if_pc=3004 for 3 cycles -> next word (3008) parked in skid, imem_req=0 in HOLD, if_pc=3008 one cycle after stall drops, no loss/duplication.
REQ-033: Ack delayed 3 cycles, redirect to 32'h0000_4002 in cycle 1 of wait -> DROP, imem_addr stays old value until ack, next request addr=32'h0000_4000, stale word never on if_instr.
REQ-034: redirect_valid=1 with stall=1 and ack same cycle -> if_valid=0 next cycle, next imem_addr=redirect target.
REQ-035: Redirect to 32'hFFFF_FFFC, ack each cycle -> if_pc FFFF_FFFC then 0000_0000.
REQ-036: Assert reset=0 asynchronously mid-DROP -> all outputs at reset values before next clk edge; after release fetch restarts at 32'h0000_3000.
